regwrite_arbiter: RTL
=====================

# regwrite_arbiter

Round-robin arbiter and sequencer for the shared write port of the general-purpose register bank: the eight negedge-triggered 16-bit registers, each with an active-low write enable. Up to NREQ datapath sources compete for the single write port using a valid/ready handshake. Typical sources are the ALU result, the memory load data and the PC-link write. Each cycle the arbiter grants one source and drives the registered one-hot active-low write strobes and write data, which the register bank captures on the following falling edge.

## Interface
- NREQ, 3, number of requesters (2..4)
- NREG, 8, number of target registers
- AW, 3, register address width; NREG must be ≤ 2^AW
- DW, 16, data width
- clk  input  1  clock; arbiter state updates on the rising edge
- reset  input  1  reset, synchronous, active-low
- stall  input  1  active-high; while 1, no grants are issued
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*AW  register index, requester i in bits [i*AW +: AW]
- req_data  input  NREQ*DW  write data, requester i in bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; combinational from req_valid, stall, reset and the pointer
- wr_n  output  NREG  one-hot active-low write strobes to the register bank
- wr_data  output  DW  data to the register bank
- wr_src  output  2  index of the requester whose write is currently presented
- err_addr  output  1  sticky flag; a granted address was ≥ NREG

## Operation
- A transfer occurs on any rising edge where req_valid[i] and req_ready[i] are both 1. At most one req_ready bit is 1 per cycle.
- Arbitration is round-robin from the priority pointer `ptr`. The first valid requester scanning ptr, ptr+1, … (mod NREQ) wins.
- After a grant to requester i, ptr becomes (i+1) mod NREQ. With no grant, ptr is unchanged.
- req_ready is all-zero under any of these conditions:
  - reset = 0
  - stall = 1
  - no valid requester
- Output stage is registered. On a transfer edge:
  - wr_n ← ~(1 << addr)
  - wr_data ← req_data of the winner
  - wr_src ← i
- On an edge with no transfer:
  - wr_n ← all ones
  - wr_data holds
  - wr_src holds
- Out-of-range address (addr ≥ NREG) is still handshaken and advances ptr. wr_n stays all ones and err_addr sets. Only reset clears err_addr.
- Requesters must hold req_valid, req_addr and req_data stable until accepted. The arbiter never drops a valid request.
- Two requesters targeting the same register in consecutive cycles produce two ordered strobes. The later grant wins in the register bank.
- Reset values, applied when reset = 0 at a rising edge:
  - wr_n = all ones
  - wr_data = 0
  - wr_src = 0
  - err_addr = 0
  - ptr = 0, so requester 0 has first priority

## Timing
- Grant to strobe latency is 1 cycle. A request accepted at edge t has wr_n low from edge t until edge t+1.
- The register bank captures on the falling edge between t and t+1. wr_n and wr_data are therefore stable for the full capture window.
- Each strobe lasts exactly one cycle, and sustained throughput is one write per cycle.
- A single continuously valid requester is granted every cycle. With k requesters continuously valid, each is granted once every k cycles.
- stall asserted in cycle t suppresses the grant at edge t. A strobe issued at edge t−1 still completes.
- Reset mid-operation: a strobe in flight is cancelled, because wr_n goes all ones at the reset edge. Requests pending during reset are not accepted and are not lost; requesters keep them valid.
- If stall and reset occur together, reset dominates.

## Test plan
- Reset: hold reset=0 for 2 cycles with all requesters valid, then release.
  - During reset: req_ready = 000, wr_n = 8'hFF, wr_data = 0, err_addr = 0.
  - First grant after release goes to requester 0.
- Single write: requester 1 sends addr 5, data 16'hBEEF for one accepted cycle.
  - Next cycle: wr_n = 8'hDF, wr_data = 16'hBEEF, wr_src = 1.
  - Following cycle: wr_n = 8'hFF.
- Fairness: all 3 requesters held valid with addrs 1/2/3 for 6 cycles.
  - Grant order is 0,1,2,0,1,2.
  - wr_n sequence is FD, FB, F7 repeating.
- Stall: requester 2 held valid with stall=1 for 3 cycles, then stall dropped.
  - No grant and wr_n = FF during the stall.
  - Grant on the first edge after stall=0; ptr is unchanged across the stall.
- Out-of-range: NREG=6, requester 0 sends addr 7.
  - Handshake completes, wr_n = all ones, err_addr = 1 and stays set until reset.
- Reset mid-op: reset=0 on the edge after requester 0 is granted with addr 4.
  - wr_n returns to FF at that edge and ptr = 0.
  - Requester 0 is re-granted after reset is released.

Source files
------------

// File: rtl/regwrite_arbiter_if.sv
// Write-port bus between the datapath requesters and the register-bank arbiter.
// Requesters drive the request side; the arbiter returns grants and the strobe stage.
interface regwrite_arbiter_if #(
   parameter int NREQ = 3,
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = 16
) ();
   logic                 stall;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic [NREG-1:0]      wr_n;
   logic [DW-1:0]        wr_data;
   logic [1:0]           wr_src;
   logic                 err_addr;

   modport master (
      output stall, req_valid, req_addr, req_data,
      input  req_ready, wr_n, wr_data, wr_src, err_addr
   );

   modport slave (
      input  stall, req_valid, req_addr, req_data,
      output req_ready, wr_n, wr_data, wr_src, err_addr
   );
endinterface

// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter for the register-bank write port: one grant per cycle and a
// registered one-hot active-low strobe held stable for the next falling-edge capture.
module regwrite_arbiter #(
   parameter int NREQ = 3,
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = 16
) (
   input logic               clk,
   input logic               reset,
   regwrite_arbiter_if.slave bus
);
   logic [1:0]      ptr_q, ptr_d;
   logic [NREQ-1:0] grant;
   logic            found;
   logic [1:0]      win;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            in_range;
   logic [NREG-1:0] wr_n_q, wr_n_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [1:0]      wr_src_q, wr_src_d;
   logic            err_q, err_d;

   always_comb begin
      grant    = '0;
      found    = 1'b0;
      win      = '0;
      sel_addr = '0;
      sel_data = '0;
      if (reset && !bus.stall) begin
         // Scan indices at or above the pointer first, then wrap to the ones below it.
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i] && i >= 32'(ptr_q)) begin
               found    = 1'b1;
               win      = 2'(i);
               grant[i] = 1'b1;
               sel_addr = bus.req_addr[i*AW +: AW];
               sel_data = bus.req_data[i*DW +: DW];
            end
         end
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i] && i < 32'(ptr_q)) begin
               found    = 1'b1;
               win      = 2'(i);
               grant[i] = 1'b1;
               sel_addr = bus.req_addr[i*AW +: AW];
               sel_data = bus.req_data[i*DW +: DW];
            end
         end
      end
   end

   always_comb begin
      in_range  = (32'(sel_addr) < NREG);
      ptr_d     = ptr_q;
      wr_n_d    = '1;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;
      err_d     = err_q;
      if (found) begin
         ptr_d     = (32'(win) + 1 >= NREQ) ? 2'd0 : win + 2'd1;
         wr_data_d = sel_data;
         wr_src_d  = win;
         // Out-of-range targets complete the handshake but never strobe a register.
         if (in_range) wr_n_d = ~(NREG'(1) << sel_addr);
         else          err_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q     <= '0;
         wr_n_q    <= '1;
         wr_data_q <= '0;
         wr_src_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         wr_n_q    <= wr_n_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
         err_q     <= err_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.wr_n      = wr_n_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.wr_src    = wr_src_q;
   assign bus.err_addr  = err_q;
endmodule
